axi_burst_beat_gen: RTL and testbench

Parametrised AXI4 burst-to-beat address generator for the SRAM slave datapath. It accepts AR/AW-style commands into a small command queue and expands each one into per-beat SRAM requests. Each request carries the beat address, byte-lane mask, beat index, last flag and a protocol-error flag. It supports FIXED, INCR and WRAP bursts at any size up to the data width, with back-to-back commands and no inter-burst bubble.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_burst_beat_gen_if.sv | 32 +++
 rtl/axi_beat_step.sv | 85 ++++++++
 rtl/axi_burst_beat_gen.sv | 138 +++++++++++++
 tb/tb_axi_burst_beat_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI types for the burst-to-beat generator: burst encoding,
// 4 KB page constant and the queued command record.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    // INCR bursts may not cross a 2^AXI_PAGE_BITS byte boundary.
    localparam int AXI_PAGE_BITS = 12;

    // Widest address the command record can carry; narrower buses zero-extend.
    localparam int AXI_CMD_ADDR_W = 64;

    typedef struct packed {
        logic [AXI_CMD_ADDR_W-1:0] addr;
        logic [2:0]                size;
        burst_e                    burst;
        logic [7:0]                len;
    } axi_cmd_t;

endpackage

// File: rtl/axi_burst_beat_gen_if.sv
// Command and beat-request bundle of the burst-to-beat generator.
// The slave modport is the generator, the master modport its environment.
interface axi_burst_beat_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [2:0]              asize_i;
    logic [1:0]              aburst_i;
    logic [7:0]              alen_i;
    logic                    avalid_i;
    logic                    aready_o;
    logic [ADDR_WIDTH-1:0]   beat_addr_o;
    logic [DATA_WIDTH/8-1:0] beat_strb_o;
    logic [7:0]              beat_idx_o;
    logic                    beat_last_o;
    logic                    beat_err_o;
    logic                    beat_valid_o;
    logic                    beat_ready_i;

    modport slave (
        input  addr_i, asize_i, aburst_i, alen_i, avalid_i, beat_ready_i,
        output aready_o, beat_addr_o, beat_strb_o, beat_idx_o,
               beat_last_o, beat_err_o, beat_valid_o
    );

    modport master (
        output addr_i, asize_i, aburst_i, alen_i, avalid_i, beat_ready_i,
        input  aready_o, beat_addr_o, beat_strb_o, beat_idx_o,
               beat_last_o, beat_err_o, beat_valid_o
    );
endinterface

// File: rtl/axi_beat_step.sv
// Combinational beat arithmetic: next address and lane mask for the burst
// in flight, plus first-beat lane mask and legality of the queue head.
module axi_beat_step
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0]    cur_addr_i,
    input  logic [2:0]               cur_size_i,
    input  burst_e                   cur_burst_i,
    input  logic [7:0]               cur_len_i,
    input  logic [AXI_PAGE_BITS-1:0] head_addr_i,
    input  logic [2:0]               head_size_i,
    input  burst_e                   head_burst_i,
    input  logic [7:0]               head_len_i,
    output logic [ADDR_WIDTH-1:0]    nxt_addr_o,
    output logic [DATA_WIDTH/8-1:0]  nxt_strb_o,
    output logic [DATA_WIDTH/8-1:0]  head_strb_o,
    output logic                     head_err_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG     = $clog2(STRB_W);

    // Sizes wider than the bus are treated as a full-bus beat.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return ({29'd0, s} > 32'(LG)) ? 3'(LG) : s;
    endfunction

    // Total bytes of the burst: (len+1) << size, 9-bit beat count shifted.
    function automatic logic [12:0] burst_span(input logic [7:0] len, input logic [2:0] s);
        logic [8:0] beats;
        beats = {1'b0, len} + 9'd1;
        return {4'd0, beats} << s;
    endfunction

    // Lanes from the address offset to the end of its size-aligned container.
    function automatic logic [STRB_W-1:0] lane_mask(input logic [11:0] a, input logic [2:0] s);
        logic [12:0]       off, b, hi;
        logic [STRB_W-1:0] m;
        b   = 13'd1 << s;
        off = {1'b0, a} & 13'(STRB_W - 1);
        hi  = (off & ~(b - 13'd1)) + b;
        for (int i = 0; i < STRB_W; i++) begin
            m[i] = (13'(i) >= off) && (13'(i) < hi);
        end
        return m;
    endfunction

    logic [2:0]  c_sz, h_sz;
    logic [12:0] c_b, c_al, c_inc, c_wm, h_b, h_al, h_span;
    logic        h_wrap_ok;

    // Next beat address and lanes for the burst in flight.
    always_comb begin
        c_sz  = clamp_size(cur_size_i);
        c_b   = 13'd1 << c_sz;
        c_al  = {1'b0, cur_addr_i[11:0]} & ~(c_b - 13'd1);
        c_inc = c_al + c_b;
        c_wm  = burst_span(cur_len_i, c_sz) - 13'd1;
        nxt_addr_o = cur_addr_i;
        case (cur_burst_i)
            BURST_FIXED: nxt_addr_o = cur_addr_i;
            BURST_WRAP:  nxt_addr_o = (cur_addr_i & ~ADDR_WIDTH'(c_wm)) | ADDR_WIDTH'(c_inc & c_wm);
            default:     nxt_addr_o[11:0] = c_inc[11:0];
        endcase
        nxt_strb_o = lane_mask(nxt_addr_o[11:0], c_sz);
    end

    // First-beat lanes and legality of the command waiting at the queue head.
    always_comb begin
        h_sz      = clamp_size(head_size_i);
        h_b       = 13'd1 << h_sz;
        h_al      = {1'b0, head_addr_i} & ~(h_b - 13'd1);
        h_span    = burst_span(head_len_i, h_sz);
        h_wrap_ok = (head_len_i == 8'd1) || (head_len_i == 8'd3) ||
                    (head_len_i == 8'd7) || (head_len_i == 8'd15);
        head_strb_o = lane_mask(head_addr_i, h_sz);
        head_err_o  = (head_burst_i == BURST_RSVD) ||
                      ((head_burst_i == BURST_WRAP) && !h_wrap_ok) ||
                      ((head_burst_i == BURST_FIXED) && (head_len_i > 8'd15)) ||
                      ({29'd0, head_size_i} > 32'(LG)) ||
                      ((head_burst_i == BURST_INCR) && ((h_al + h_span) > 13'd4096));
    end
endmodule

// File: rtl/axi_burst_beat_gen.sv
// AXI4 burst-to-beat address generator: queues AR/AW commands and expands
// each into per-beat SRAM requests, one beat per cycle, with no bubble
// between consecutive bursts.
module axi_burst_beat_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 2
) (
    input  logic                aclk_i,
    input  logic                areset_i,
    axi_burst_beat_gen_if.slave bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    axi_cmd_t                  mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      q_full, q_empty, push, pop, beat_hs;
    axi_cmd_t                  cmd_in, head_cmd;
    logic [AXI_CMD_ADDR_W-1:0] unused_head_addr;

    state_e                    state_q;
    logic [ADDR_WIDTH-1:0]     beat_addr_q;
    logic [STRB_W-1:0]         beat_strb_q;
    logic [7:0]                beat_idx_q;
    logic                      beat_last_q, beat_err_q, beat_valid_q;
    logic [2:0]                cur_size_q;
    burst_e                    cur_burst_q;
    logic [7:0]                cur_len_q;

    logic [ADDR_WIDTH-1:0]     nxt_addr_d;
    logic [STRB_W-1:0]         nxt_strb_d, head_strb_d;
    logic                      head_err_d;

    assign q_full   = (cnt_q == CNT_W'(CMD_DEPTH));
    assign q_empty  = (cnt_q == '0);
    assign push     = bus.avalid_i & ~q_full;
    assign beat_hs  = beat_valid_q & bus.beat_ready_i;
    // The head is consumed when idle, or in the same edge the last beat
    // retires; a command pushed in that edge is not visible until the next.
    assign pop      = ~q_empty & ((state_q == ST_IDLE) | (beat_hs & beat_last_q));

    assign cmd_in.addr  = AXI_CMD_ADDR_W'(bus.addr_i);
    assign cmd_in.size  = bus.asize_i;
    assign cmd_in.burst = burst_e'(bus.aburst_i);
    assign cmd_in.len   = bus.alen_i;
    assign head_cmd     = mem_q[rd_ptr_q];
    assign unused_head_addr = head_cmd.addr;

    // Command storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge aclk_i) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    axi_beat_step #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .cur_addr_i   (beat_addr_q),
        .cur_size_i   (cur_size_q),
        .cur_burst_i  (cur_burst_q),
        .cur_len_i    (cur_len_q),
        .head_addr_i  (head_cmd.addr[AXI_PAGE_BITS-1:0]),
        .head_size_i  (head_cmd.size),
        .head_burst_i (head_cmd.burst),
        .head_len_i   (head_cmd.len),
        .nxt_addr_o   (nxt_addr_d),
        .nxt_strb_o   (nxt_strb_d),
        .head_strb_o  (head_strb_d),
        .head_err_o   (head_err_d)
    );

    // Burst FSM: load a command, step through its beats, chain into the next.
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q      <= ST_IDLE;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
            beat_err_q   <= 1'b0;
            beat_addr_q  <= '0;
            beat_strb_q  <= '0;
            beat_idx_q   <= '0;
            cur_size_q   <= '0;
            cur_burst_q  <= BURST_FIXED;
            cur_len_q    <= '0;
        end else if (pop) begin
            state_q      <= ST_BURST;
            beat_valid_q <= 1'b1;
            beat_addr_q  <= head_cmd.addr[ADDR_WIDTH-1:0];
            beat_strb_q  <= head_strb_d;
            beat_idx_q   <= '0;
            beat_last_q  <= (head_cmd.len == 8'd0);
            beat_err_q   <= head_err_d;
            cur_size_q   <= head_cmd.size;
            cur_burst_q  <= head_cmd.burst;
            cur_len_q    <= head_cmd.len;
        end else if (beat_hs && !beat_last_q) begin
            beat_addr_q  <= nxt_addr_d;
            beat_strb_q  <= nxt_strb_d;
            beat_idx_q   <= beat_idx_q + 8'd1;
            beat_last_q  <= ((beat_idx_q + 8'd1) == cur_len_q);
        end else if (beat_hs) begin
            state_q      <= ST_IDLE;
            beat_valid_q <= 1'b0;
        end
    end

    assign bus.aready_o     = ~q_full;
    assign bus.beat_addr_o  = beat_addr_q;
    assign bus.beat_strb_o  = beat_strb_q;
    assign bus.beat_idx_o   = beat_idx_q;
    assign bus.beat_last_o  = beat_last_q;
    assign bus.beat_err_o   = beat_err_q;
    assign bus.beat_valid_o = beat_valid_q;
endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Scoreboard bench for axi_burst_beat_gen on a 32-bit bus, depth-2 queue.
module tb_axi_burst_beat_gen;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [7:0]  idx;
        logic        last;
        logic        err;
    } beat_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_burst_beat_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    axi_burst_beat_gen #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CMD_DEPTH  (2)
    ) dut (
        .aclk_i   (aclk),
        .areset_i (areset),
        .bus      (bus)
    );

    beat_t sbq[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    chk_bubble = 1'b0;
    bit    acc_flag;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Lanes belong to the container (i / b) holding the offset, at or above it.
    function automatic logic [3:0] exp_strb(input logic [31:0] a, input int b);
        int         off;
        logic [3:0] m;
        off = int'(a[1:0]);
        m   = '0;
        for (int i = 0; i < 4; i++) if ((i / b == off / b) && (i >= off)) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_push(input logic [31:0] a, input int size, input int burst, input int len);
        int          sz, b, w;
        logic        err;
        logic [31:0] cur, aligned;
        beat_t       e;
        sz  = (size > 2) ? 2 : size;
        b   = 1 << sz;
        w   = (len + 1) * b;
        err = (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15})) ||
              (burst == 0 && len > 15) || (size > 2) ||
              (burst == 1 && ((int'(a[11:0]) & ~(b - 1)) + w > 4096));
        cur = a;
        for (int i = 0; i <= len; i++) begin
            e.addr = cur;
            e.strb = exp_strb(cur, b);
            e.idx  = 8'(i);
            e.last = (i == len);
            e.err  = err;
            sbq.push_back(e);
            aligned = cur & ~32'(b - 1);
            if (burst == 2)      cur = (cur & ~32'(w - 1)) | ((aligned + 32'(b)) & 32'(w - 1));
            else if (burst != 0) cur = {cur[31:12], 12'(aligned + 32'(b))};
        end
    endtask

    task automatic sample_beat();
        beat_t got;
        if (chk_bubble && sbq.size() > 0) check_eq("no_bubble", {63'd0, bus.beat_valid_o}, 64'd1);
        if (bus.beat_valid_o) begin
            got = {bus.beat_addr_o, bus.beat_strb_o, bus.beat_idx_o, bus.beat_last_o, bus.beat_err_o};
            if (sbq.size() == 0) begin
                check_eq("unexpected_beat", {63'd0, bus.beat_valid_o}, 64'd0);
            end else begin
                check_eq($sformatf("beat%0d", sbq[0].idx), 64'(got), 64'(sbq[0]));
                if (bus.beat_ready_i) void'(sbq.pop_front());
            end
        end
    endtask

    // One clock: check outputs and note a command handshake at the falling
    // edge, then return just after the rising edge.
    task automatic cycle();
        @(negedge aclk);
        sample_beat();
        if (bus.avalid_i && bus.aready_o && !areset) begin
            acc_flag = 1'b1;
            model_push(bus.addr_i, int'(bus.asize_i), int'(bus.aburst_i), int'(bus.alen_i));
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input int size, input int burst, input int len);
        bus.addr_i   = a;
        bus.asize_i  = 3'(size);
        bus.aburst_i = 2'(burst);
        bus.alen_i   = 8'(len);
        bus.avalid_i = 1'b1;
        acc_flag     = 1'b0;
        for (int k = 0; k < 64 && !acc_flag; k++) cycle();
        bus.avalid_i = 1'b0;
        check_eq("cmd_accept", {63'd0, acc_flag}, 64'd1);
    endtask

    task automatic drain(input int maxc, input bit rand_ready);
        for (int k = 0; k < maxc && sbq.size() > 0; k++) begin
            if (rand_ready) bus.beat_ready_i = 1'($urandom_range(0, 1));
            cycle();
        end
        check_eq("drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        bus.addr_i = '0; bus.asize_i = '0; bus.aburst_i = '0; bus.alen_i = '0;
        bus.avalid_i = 1'b0; bus.beat_ready_i = 1'b1;
        repeat (3) cycle();
        check_eq("reset_outs", {18'd0, bus.beat_valid_o, bus.beat_last_o, bus.beat_err_o,
                 bus.beat_addr_o, bus.beat_strb_o, bus.beat_idx_o}, 64'd0);
        check_eq("reset_aready", {63'd0, bus.aready_o}, 64'd1);
        areset = 1'b0;
        cycle();

        // INCR with first-beat latency
        send_cmd(32'h1002, 2, 1, 3);
        check_eq("lat_n", {63'd0, bus.beat_valid_o}, 64'd0);
        cycle();
        check_eq("lat_n1", {63'd0, bus.beat_valid_o}, 64'd1);
        drain(40, 1'b0);

        send_cmd(32'h38, 2, 2, 3);    drain(40, 1'b0);   // WRAP legal
        send_cmd(32'h38, 2, 2, 2);    drain(40, 1'b0);   // WRAP bad len
        send_cmd(32'h21, 0, 0, 2);    drain(40, 1'b0);   // FIXED byte
        send_cmd(32'h40, 2, 0, 16);   drain(60, 1'b0);   // FIXED len 16
        send_cmd(32'hFF8, 2, 1, 3);   drain(40, 1'b0);   // page crossing
        send_cmd(32'h100, 3, 1, 1);   drain(40, 1'b0);   // oversize beat
        send_cmd(32'h200, 2, 3, 1);   drain(40, 1'b0);   // reserved burst

        // Back-to-back commands into a stalled consumer, then free-running
        bus.beat_ready_i = 1'b0;
        send_cmd(32'h1000, 2, 1, 1);
        send_cmd(32'h2010, 2, 2, 3);
        send_cmd(32'h3003, 0, 0, 2);
        check_eq("full_aready", {63'd0, bus.aready_o}, 64'd0);
        cycle();
        bus.beat_ready_i = 1'b1;
        chk_bubble = 1'b1;
        drain(40, 1'b0);
        chk_bubble = 1'b0;
        check_eq("aready_after", {63'd0, bus.aready_o}, 64'd1);

        // Random backpressure across two bursts
        bus.beat_ready_i = 1'b0;
        send_cmd(32'h500, 1, 1, 7);
        send_cmd(32'h7C, 2, 2, 7);
        drain(400, 1'b1);
        bus.beat_ready_i = 1'b1;

        // Asynchronous reset in the middle of a burst
        send_cmd(32'h400, 2, 1, 7);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus.beat_valid_o && bus.beat_idx_o == 8'd2) break;
        end
        check_eq("reached_beat2", {55'd0, bus.beat_valid_o, bus.beat_idx_o}, {55'd0, 1'b1, 8'd2});
        areset = 1'b1;
        #1;
        check_eq("midrst_outs", {18'd0, bus.beat_valid_o, bus.beat_last_o, bus.beat_err_o,
                 bus.beat_addr_o, bus.beat_strb_o, bus.beat_idx_o}, 64'd0);
        check_eq("midrst_aready", {63'd0, bus.aready_o}, 64'd1);
        sbq.delete();
        repeat (2) cycle();
        areset = 1'b0;
        repeat (5) cycle();
        check_eq("idle_after_rst", {63'd0, bus.beat_valid_o}, 64'd0);
        send_cmd(32'h800, 2, 1, 1);
        drain(40, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
